// File: rtl/cp0_reg_if.sv
// CP0 software access port: the MTC0 write committed at write-back and the
// MFC0 read issued from execute.
//
// Handshake: there is no valid/ready pair on this port. A write is an
// unconditional one-cycle strobe: when we_i is high at a rising edge,
// data_i is committed to register waddr_i. The read is a pure
// combinational lookup: data_o reflects raddr_i in the same cycle and is
// always accepted.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  // Pipeline side: drives the write strobe and read address.
  modport master (
    output we_i, waddr_i, data_i, raddr_i,
    input  data_o
  );

  // CP0 side: accepts writes and answers reads.
  modport slave (
    input  we_i, waddr_i, data_i, raddr_i,
    output data_o
  );
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status/Cause/EPC,
// read-only PRId/Config, and exception-context capture from the memory stage.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  cp0_reg_if.slave    bus,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic        timer_q,   timer_d;

  logic        exc_valid;
  logic [4:0]  exc_code;

  // Decode the committed exception type into an ExcCode; ERET is handled apart.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    case (excepttype_i)
      32'h1: begin exc_valid = 1'b1; exc_code = 5'd0;  end
      32'h8: begin exc_valid = 1'b1; exc_code = 5'd8;  end
      32'ha: begin exc_valid = 1'b1; exc_code = 5'd10; end
      32'hc: begin exc_valid = 1'b1; exc_code = 5'd12; end
      32'hd: begin exc_valid = 1'b1; exc_code = 5'd13; end
      default: ;
    endcase
  end

  // Next-state: software write first, then exception commit overrides it.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    // Timer request is sticky until Compare is rewritten.
    timer_d   = timer_q | ((compare_q != 32'd0) && (count_q == compare_q));

    // Hardware interrupt lines are sampled into Cause.IP[7:2] every cycle.
    cause_d[15:10] = int_i;

    if (bus.we_i) begin
      case (bus.waddr_i)
        REG_COUNT:   count_d = bus.data_i;
        REG_COMPARE: begin
          compare_d = bus.data_i;
          timer_d   = 1'b0;
        end
        REG_STATUS:  status_d = bus.data_i;
        REG_CAUSE: begin
          cause_d[9:8]   = bus.data_i[9:8];
          cause_d[23:22] = bus.data_i[23:22];
        end
        REG_EPC:     epc_d = bus.data_i;
        default: ;
      endcase
    end

    if (exc_valid) begin
      // A nested exception (EXL already set) keeps the original return context.
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                        : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
        status_d[1] = 1'b1;
      end
      cause_d[6:2] = exc_code;
    end else if (excepttype_i == 32'he) begin
      status_d[1] = 1'b0;
    end
  end

  // State registers, asynchronously cleared to architectural reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RESET;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  // MFC0 read: stored values only, no bypass of a same-cycle write.
  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      REG_COUNT:   bus.data_o = count_q;
      REG_COMPARE: bus.data_o = compare_q;
      REG_STATUS:  bus.data_o = status_q;
      REG_CAUSE:   bus.data_o = cause_q;
      REG_EPC:     bus.data_o = epc_q;
      REG_PRID:    bus.data_o = PRID_VALUE;
      REG_CONFIG:  bus.data_o = CONFIG_VALUE;
      default:     bus.data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file: the responder for the execute stage's CP0 read port and for the MTC0 write committed at write-back, plus the exception-state owner. It holds Count/Compare/Status/Cause/EPC/PRId/Config, runs the Count timer, and latches exception context (EPC, Cause.BD, ExcCode, Status.EXL) from the exception-commit point in the memory stage. Outputs feed the interrupt/exception logic and the execute stage's MFC0 path.

## Interface
- PRID_VALUE, 32'h00480102, read-only PRId contents
- CONFIG_VALUE, 32'h00008000, reset/read-only Config contents (BE=1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- we_i  in  1  write enable (MTC0 at write-back)
- waddr_i  in  5  write register number
- data_i  in  32  write data
- raddr_i  in  5  read register number
- int_i  in  6  hardware interrupt lines, level-sensitive
- excepttype_i  in  32  committed exception code (0 = none)
- current_inst_addr_i  in  32  PC of excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- data_o  out  32  read data for raddr_i (combinational)
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents
- timer_int_o  out  1  timer interrupt request

## Operation
- Register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. All others read 0, writes ignored.
- Read: data_o = stored value of raddr_i; no bypass of a same-cycle write (the execute stage forwards from mem/wb itself).
- Count: +1 every cycle, wraps 32'hFFFFFFFF -> 0. A write to Count loads data_i that cycle instead of incrementing.
- Compare: a write loads data_i and clears timer_int_o.
- Timer: if compare_o != 0 and count_o == compare_o, timer_int_o <= 1 on the next edge; it stays set until a Compare write or reset.
- Status: fully writable.
- Cause: bits [15:10] <= int_i every cycle (not software-writable). Writable fields are only IP[9:8], WP[22], and IV[23]; all other bits are unaffected by writes.
- EPC: fully writable. PRId and Config are read-only; writes are ignored.
- Exception commit, applied after any same-cycle software write (exception wins on conflicting bits):
  - 32'h1 interrupt -> ExcCode 0
  - 32'h8 syscall -> 8
  - 32'ha reserved instruction -> 10
  - 32'hc overflow -> 12
  - 32'hd trap -> 13
- For the codes above:
  - If Status.EXL = 0: EPC <= is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i; Cause.BD[31] <= is_in_delayslot_i; Status.EXL[1] <= 1.
  - If Status.EXL = 1: EPC and BD are unchanged.
  - In both cases Cause[6:2] <= ExcCode.
- 32'he (ERET): Status.EXL <= 0; EPC and Cause are unchanged.
- Any other nonzero code is ignored.

## Timing
- Reset (rst low, async): count_o 0, compare_o 0, status_o 32'h10000000, cause_o 0, epc_o 0, timer_int_o 0, config_o CONFIG_VALUE, prid_o PRID_VALUE.
- Count resumes at 0 on the first edge after reset deassertion, then 1, 2, ...
- Write and exception updates are visible on *_o one cycle after the edge they are sampled on. data_o follows raddr_i combinationally.
- timer_int_o rises one edge after the match cycle.
- Compare write coinciding with a match: the clear wins, so timer_int_o is 0.
- Cause.IP[7:2] tracks int_i with one cycle of latency.
- Reset asserted mid-operation overrides all pending writes and exceptions immediately.

## Test plan
- Reset values: release rst -> status_o = 32'h10000000, config_o = 32'h00008000, prid_o = 32'h00480102, other outputs 0; count_o reads 5 after 5 edges.
- Timer: write Compare = 20, then Count = 10 -> timer_int_o = 1 exactly 11 edges later; write Compare = 40 -> timer_int_o = 0 on the next edge.
- Readback: write Status = 32'h1000FF01 -> raddr_i = 12 returns it. Write Cause = 32'hFFFFFFFF with int_i = 0 -> cause_o = 32'h00C00300. Write PRId -> unchanged.
- Delay-slot exception: EXL = 0, excepttype_i = 32'hc, addr 32'h80001004, delay slot = 1 -> EPC = 32'h80001000, Cause[31] = 1, Cause[6:2] = 12, Status[1] = 1.
- Nested, then ERET: with EXL = 1, syscall at addr 32'h80002000 -> EPC unchanged, ExcCode = 8; then excepttype_i = 32'he -> Status[1] = 0.
- Conflict/reset: same-cycle EPC write (32'h1234) and overflow at 32'h80000010 with EXL = 0 -> EPC = 32'h80000010. Assert rst mid-count -> count_o = 0 without waiting for a clock edge.
